// File: rtl/bbc_keyboard_types.sv
// Shared types for the BBC micro keyboard matrix model: the registered keyboard
// state from the CSR source, the VIA/IC32 control bundle and the response bundle.
package bbc_keyboard_types;

    localparam int bbc_keyboard_num_columns = 10;
    localparam int bbc_keyboard_matrix_w    = 8 * bbc_keyboard_num_columns;

    typedef struct packed {
        logic        reset_pressed;
        logic [63:0] keys_down_cols_0_to_7;
        logic [15:0] keys_down_cols_8_to_9;
    } t_bbc_keyboard;

    typedef struct packed {
        logic       enable_n;
        logic [3:0] column;
        logic [2:0] row;
    } t_bbc_keyboard_control;

    typedef struct packed {
        logic       key_pressed;
        logic       column_activity;
        logic       reset_pressed;
        logic [3:0] scan_column;
    } t_bbc_keyboard_response;

endpackage

// File: rtl/bbc_keyboard_column_select.sv
// Combinational column lookup: picks the 8 row bits of one column out of the
// flattened 80-bit key matrix. Columns past the physical matrix read as no keys.
module bbc_keyboard_column_select
    import bbc_keyboard_types::*;
(
    input  logic [3:0]                       column,
    input  logic [bbc_keyboard_matrix_w-1:0] matrix,
    output logic [7:0]                       column_bits
);

    // Select one byte of the matrix, or zero for the unpopulated columns 10-15
    always_comb begin
        column_bits = '0;
        if (column < 4'(bbc_keyboard_num_columns)) begin
            column_bits = matrix[{column, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/bbc_keyboard_matrix.sv
// BBC micro keyboard matrix as seen by the system VIA.
// Auto-scan mode walks a 4-bit column counter and flags activity in rows 1-7;
// direct mode reports the single key addressed by the VIA column/row.
// Optional feature: define BBC_KEYBOARD_MATRIX_SNAPSHOT_EN to scan from an
// 80-bit snapshot taken at each scan wrap (and every cycle in direct mode).
module bbc_keyboard_matrix
    import bbc_keyboard_types::*;
#(
    parameter int SCAN_DIVIDE = 1
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        keyboard__reset_pressed,
    input  logic [63:0] keyboard__keys_down_cols_0_to_7,
    input  logic [15:0] keyboard__keys_down_cols_8_to_9,
    input  logic        keyboard_control__enable_n,
    input  logic [3:0]  keyboard_control__column,
    input  logic [2:0]  keyboard_control__row,
    output logic        keyboard_response__key_pressed,
    output logic        keyboard_response__column_activity,
    output logic        keyboard_response__reset_pressed,
    output logic [3:0]  keyboard_response__scan_column
);

    localparam logic [3:0] PRESCALE_LAST = 4'(SCAN_DIVIDE - 1);

    t_bbc_keyboard                    keyboard;
    t_bbc_keyboard_control            control;
    t_bbc_keyboard_response           response_p1;
    logic [3:0]                       counter;
    logic [3:0]                       prescaler;
    logic                             step;
    logic [bbc_keyboard_matrix_w-1:0] live_matrix;
    logic [bbc_keyboard_matrix_w-1:0] lookup_matrix;
    logic [7:0]                       column_bits;

    assign keyboard.reset_pressed         = keyboard__reset_pressed;
    assign keyboard.keys_down_cols_0_to_7 = keyboard__keys_down_cols_0_to_7;
    assign keyboard.keys_down_cols_8_to_9 = keyboard__keys_down_cols_8_to_9;

    assign control.enable_n = keyboard_control__enable_n;
    assign control.column   = keyboard_control__column;
    assign control.row      = keyboard_control__row;

    // Column c lives at bits [8c+7:8c]; columns 8 and 9 sit above the first 64 bits
    assign live_matrix = {keyboard.keys_down_cols_8_to_9, keyboard.keys_down_cols_0_to_7};

    // Counter advances on the last prescale count of an auto-scan cycle
    assign step = control.enable_n && (prescaler == PRESCALE_LAST);

`ifdef BBC_KEYBOARD_MATRIX_SNAPSHOT_EN
    logic                             wrap;
    logic [bbc_keyboard_matrix_w-1:0] snapshot;

    assign wrap = step && (counter == 4'hF);

    // Capture the matrix at the start of every scan pass, and continuously in direct mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snapshot <= '0;
        end else if (clk__enable && (wrap || !control.enable_n)) begin
            snapshot <= live_matrix;
        end
    end

    assign lookup_matrix = snapshot;
`else
    assign lookup_matrix = live_matrix;
`endif

    bbc_keyboard_column_select u_column_select (
        .column      (counter),
        .matrix      (lookup_matrix),
        .column_bits (column_bits)
    );

    // Column counter and prescaler: free-run in auto-scan, load from the VIA in direct mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter   <= '0;
            prescaler <= '0;
        end else if (clk__enable) begin
            if (!control.enable_n) begin
                counter   <= control.column;
                prescaler <= '0;
            end else if (step) begin
                counter   <= counter + 4'd1;
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 4'd1;
            end
        end
    end

    // Registered response: row 0 never counts as activity; key_pressed only in direct mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            response_p1 <= '0;
        end else if (clk__enable) begin
            response_p1.column_activity <= |column_bits[7:1];
            response_p1.key_pressed     <= !control.enable_n && column_bits[control.row];
            response_p1.reset_pressed   <= keyboard.reset_pressed;
            response_p1.scan_column     <= counter;
        end
    end

    assign keyboard_response__key_pressed     = response_p1.key_pressed;
    assign keyboard_response__column_activity = response_p1.column_activity;
    assign keyboard_response__reset_pressed   = response_p1.reset_pressed;
    assign keyboard_response__scan_column     = response_p1.scan_column;

endmodule
